bat_charge_ctrl: RTL

- Digital charge-mode sequencer for the Li-ion battery charger analog front end.
- Consumes ADC samples of battery voltage, battery current and battery temperature.
- Selects trickle (TC), constant-current (CC), constant-voltage (CV), done or fault mode.
- Drives the current and voltage setpoint codes and the one-hot mode flags used by the charger power stage.

---
 rtl/bat_charge_ctrl_pkg.sv | 36 +++
 rtl/bat_charge_ctrl_if.sv | 27 ++
 rtl/bat_charge_ctrl_debounce.sv | 36 +++
 rtl/bat_charge_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bat_charge_ctrl_pkg.sv
// rtl/bat_charge_ctrl_pkg.sv - shared types, constants and helpers for the charge sequencer (package bat_chg_pkg)
package bat_chg_pkg;

  // Charge sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TC    = 3'd1,
    ST_CC    = 3'd2,
    ST_CV    = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } chg_state_e;

  // ADC code weights
  localparam int VBAT_LSB_UV  = 5000;  // 5 mV per vbat LSB
  localparam int IBAT_LSB_UA  = 1000;  // 1 mA per ibat LSB
  localparam int VTEMP_LSB_UV = 500;   // 0.5 mV per vtemp LSB

  // Default threshold codes
  localparam int DEF_DEB         = 4;
  localparam int DEF_VCUTOFF     = 600;    // 3.00 V
  localparam int DEF_VCV         = 840;    // 4.20 V
  localparam int DEF_VRECHG      = 800;    // 4.00 V
  localparam int DEF_TEMP_LO     = 242;    // 0 degC
  localparam int DEF_TEMP_HI     = 515;    // 45 degC
  localparam int DEF_TMO_SAMPLES = 65535;

  // Charge current granularity per capacity step, in mA
  localparam int ICC_STEP = 50;

  // Constant-current setpoint for a capacity select: 50 mA * (sel + 1), max 800
  function automatic logic [9:0] icc_from_sel(input logic [3:0] sel);
    return 10'(ICC_STEP) * ({6'd0, sel} + 10'd1);
  endfunction

endpackage

// File: rtl/bat_charge_ctrl_if.sv
// rtl/bat_charge_ctrl_if.sv - ADC sample bus and power-stage control bundle
interface bat_chg_if;
  logic       sample_valid;
  logic [9:0] vbat_code;
  logic [9:0] ibat_code;
  logic [9:0] vtemp_code;
  logic [9:0] iset_code;
  logic [9:0] vset_code;
  logic       tc;
  logic       cc;
  logic       cv;
  logic       done;
  logic       fault;
  logic       fault_tmo;

  // ADC side: supplies samples, observes setpoints and mode flags
  modport master (
    output sample_valid, vbat_code, ibat_code, vtemp_code,
    input  iset_code, vset_code, tc, cc, cv, done, fault, fault_tmo
  );

  // Sequencer side
  modport slave (
    input  sample_valid, vbat_code, ibat_code, vtemp_code,
    output iset_code, vset_code, tc, cc, cv, done, fault, fault_tmo
  );
endinterface

// File: rtl/bat_charge_ctrl_debounce.sv
// rtl/bat_charge_ctrl_debounce.sv - consecutive-sample qualifier for mode transitions (module chg_debounce)
module chg_debounce #(
  parameter int DEB = 4
) (
  input  logic clk,
  input  logic rstz,
  input  logic clr,
  input  logic sample_valid,
  input  logic cond,
  output logic fire
);

  localparam logic [3:0] LAST = 4'(DEB - 1);

  logic [3:0] cnt_q, cnt_d;

  // Fire on the sample that completes the run of DEB qualifying samples
  assign fire = sample_valid && cond && (cnt_q == LAST);

  // Count qualifying samples; a failing sample or a state change restarts the run
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (sample_valid) begin
      cnt_d = cond ? cnt_q + 4'd1 : 4'd0;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bat_charge_ctrl.sv
// rtl/bat_charge_ctrl.sv - Li-ion charge-mode sequencer; optional safety timer under BAT_CHG_TIMEOUT_EN
module bat_charge_ctrl
  import bat_chg_pkg::*;
#(
  parameter int DEB         = DEF_DEB,
  parameter int VCUTOFF     = DEF_VCUTOFF,
  parameter int VCV         = DEF_VCV,
  parameter int VRECHG      = DEF_VRECHG,
  parameter int TEMP_LO     = DEF_TEMP_LO,
  parameter int TEMP_HI     = DEF_TEMP_HI,
  parameter int TMO_SAMPLES = DEF_TMO_SAMPLES
) (
  input  logic       clk,
  input  logic       rstz,
  input  logic       en,
  input  logic [3:0] sel,
  bat_chg_if.slave   bus
);

  chg_state_e state_q, state_d;
  logic [9:0] icc_q, icc_d, iterm_q, iterm_d;
  logic [9:0] iset_q, iset_d, vset_q, vset_d;
  logic       tc_q, tc_d, cc_q, cc_d, cv_q, cv_d;
  logic       done_q, done_d, fault_q, fault_d;
  logic       temp_ok, cond, fire, clr, tmo_hit, tmo_flag;

  assign temp_ok = (bus.vtemp_code >= 10'(TEMP_LO)) && (bus.vtemp_code <= 10'(TEMP_HI));

`ifdef BAT_CHG_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_flag_q, tmo_flag_d, fault_tmo_q;

  assign tmo_hit  = ((state_q == ST_CC) || (state_q == ST_CV)) && (tmo_cnt_q == 16'(TMO_SAMPLES));
  assign tmo_flag = tmo_flag_q;

  // Safety timer: counts samples spent charging, saturates, and clears only in IDLE
  always_comb begin
    tmo_cnt_d  = tmo_cnt_q;
    tmo_flag_d = tmo_flag_q;
    if (state_q == ST_IDLE) begin
      tmo_cnt_d  = 16'd0;
      tmo_flag_d = 1'b0;
    end else if (((state_q == ST_CC) || (state_q == ST_CV)) && bus.sample_valid &&
                 (tmo_cnt_q != 16'(TMO_SAMPLES))) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
    if (en && tmo_hit) tmo_flag_d = 1'b1;
  end

  // Safety timer registers
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      tmo_cnt_q   <= 16'd0;
      tmo_flag_q  <= 1'b0;
      fault_tmo_q <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_flag_q  <= tmo_flag_d;
      fault_tmo_q <= tmo_flag_q;
    end
  end

  assign bus.fault_tmo = fault_tmo_q;
`else
  assign tmo_hit       = 1'b0;
  assign tmo_flag      = 1'b0;
  assign bus.fault_tmo = 1'b0;
`endif

  chg_debounce #(.DEB(DEB)) u_deb (
    .clk          (clk),
    .rstz         (rstz),
    .clr          (clr),
    .sample_valid (bus.sample_valid),
    .cond         (cond),
    .fire         (fire)
  );

  // Next state: exit condition per state, then transitions in priority order
  always_comb begin
    state_d = state_q;
    cond    = 1'b0;
    case (state_q)
      ST_TC:    cond = bus.vbat_code >= 10'(VCUTOFF);
      ST_CC:    cond = bus.vbat_code >= 10'(VCV);
      ST_CV:    cond = bus.ibat_code <= iterm_q;
      ST_DONE:  cond = bus.vbat_code <  10'(VRECHG);
      ST_FAULT: cond = temp_ok && !tmo_flag;
      default:  cond = 1'b0;
    endcase
    if (!en) begin
      state_d = ST_IDLE;
    end else if (tmo_hit) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.sample_valid && temp_ok) begin
            if (bus.vbat_code < 10'(VCUTOFF))  state_d = ST_TC;
            else if (bus.vbat_code < 10'(VCV)) state_d = ST_CC;
            else                               state_d = ST_CV;
          end
        end
        ST_TC, ST_CC, ST_CV: begin
          if (bus.sample_valid && !temp_ok) state_d = ST_FAULT;
          else if (fire) state_d = (state_q == ST_TC) ? ST_CC :
                                   (state_q == ST_CC) ? ST_CV : ST_DONE;
        end
        ST_DONE:  if (fire) state_d = ST_CC;
        ST_FAULT: if (fire) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  assign clr = (state_d != state_q);

  // Capacity latch and registered setpoints/flags derived from the current state
  always_comb begin
    icc_d   = icc_q;
    iterm_d = iterm_q;
    if (state_q == ST_IDLE) begin
      icc_d   = icc_from_sel(sel);
      iterm_d = icc_from_sel(sel) >> 4;
    end
    iset_d  = 10'd0;
    vset_d  = 10'd0;
    tc_d    = (state_q == ST_TC);
    cc_d    = (state_q == ST_CC);
    cv_d    = (state_q == ST_CV);
    done_d  = (state_q == ST_DONE);
    fault_d = (state_q == ST_FAULT);
    case (state_q)
      ST_TC:        begin iset_d = icc_q >> 3; vset_d = 10'(VCV); end
      ST_CC, ST_CV: begin iset_d = icc_q;      vset_d = 10'(VCV); end
      default:      ;
    endcase
  end

  // State, capacity and output registers
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= ST_IDLE;
      icc_q   <= 10'd0;
      iterm_q <= 10'd0;
      iset_q  <= 10'd0;
      vset_q  <= 10'd0;
      tc_q    <= 1'b0;
      cc_q    <= 1'b0;
      cv_q    <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      icc_q   <= icc_d;
      iterm_q <= iterm_d;
      iset_q  <= iset_d;
      vset_q  <= vset_d;
      tc_q    <= tc_d;
      cc_q    <= cc_d;
      cv_q    <= cv_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign bus.iset_code = iset_q;
  assign bus.vset_code = vset_q;
  assign bus.tc        = tc_q;
  assign bus.cc        = cc_q;
  assign bus.cv        = cv_q;
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;

endmodule
